// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register dump reader: default widths, FSM states
// and the value every output register takes on reset.
package reg_dump_reader_pkg;

    localparam int          DEFAULT_DATA_W = 32;
    localparam int          DEFAULT_ADDR_W = 5;
    localparam int unsigned RESET_VALUE    = 0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND,
        CSUM,
        DONE
    } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register file read port and streams each value out over valid/ready.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Rd_Reg,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [ADDR_W-1:0] Out_Index,
    output logic              Out_Last
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG >= (2 ** ADDR_W)) begin : g_bad_range
        $error("reg_dump_reader: need 0 <= FIRST_REG <= LAST_REG < 2**ADDR_W");
    end

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    // The register file reads synchronously, so Rd_Reg is loaded on entry to
    // ISSUE and the returned data is taken one cycle later in CAPTURE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= FIRST_IDX;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Rd_Reg    <= ADDR_W'(RESET_VALUE);
            Out_Valid <= 1'b0;
            Out_Data  <= DATA_W'(RESET_VALUE);
            Out_Index <= ADDR_W'(RESET_VALUE);
            Out_Last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc       <= DATA_W'(RESET_VALUE);
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state  <= ISSUE;
                        idx    <= FIRST_IDX;
                        Rd_Reg <= FIRST_IDX;
                        Busy   <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        acc    <= DATA_W'(RESET_VALUE);
`endif
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    Out_Data  <= Rd_Data;
                    Out_Index <= idx;
                    Out_Valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    Out_Last  <= 1'b0;
                    acc       <= acc ^ Rd_Data;
`else
                    Out_Last  <= (idx == LAST_IDX);
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (Out_Ready) begin
                        if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // Checksum word goes out immediately, reusing the output registers.
                            Out_Data  <= acc;
                            Out_Index <= LAST_IDX;
                            Out_Valid <= 1'b1;
                            Out_Last  <= 1'b1;
                            state     <= CSUM;
`else
                            Out_Valid <= 1'b0;
                            Out_Last  <= 1'b0;
                            Done      <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            Out_Valid <= 1'b0;
                            Out_Last  <= 1'b0;
                            idx       <= idx + 1'b1;
                            Rd_Reg    <= idx + 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        Out_Last  <= 1'b0;
                        Done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full dumps, stalled consumer, sub-range dump,
// mid-dump reset and back-to-back restart. Honours REG_DUMP_CHECKSUM_EN.
module tb_reg_dump_reader;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset;
    logic          startA;
    logic          startB;
    logic          outReady;
    logic [DW-1:0] regs [32];

    logic          busyA, doneA, validA, lastA;
    logic [AW-1:0] rdRegA, indexA;
    logic [DW-1:0] rdDataA, dataA;
    logic          busyB, doneB, validB, lastB;
    logic [AW-1:0] rdRegB, indexB;
    logic [DW-1:0] rdDataB, dataB;

    logic          dutSel;
    logic          selBusy, selDone, selValid, selLast;
    logic [AW-1:0] selRdReg, selIndex;
    logic [DW-1:0] selData;

    int checkCount = 0;
    int errorCount = 0;

    always #5 Clock = ~Clock;

    reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(31)) dutA (
        .Clock(Clock), .Reset(Reset), .Start(startA), .Busy(busyA), .Done(doneA),
        .Rd_Reg(rdRegA), .Rd_Data(rdDataA), .Out_Valid(validA), .Out_Ready(outReady),
        .Out_Data(dataA), .Out_Index(indexA), .Out_Last(lastA)
    );

    reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(17), .LAST_REG(18)) dutB (
        .Clock(Clock), .Reset(Reset), .Start(startB), .Busy(busyB), .Done(doneB),
        .Rd_Reg(rdRegB), .Rd_Data(rdDataB), .Out_Valid(validB), .Out_Ready(outReady),
        .Out_Data(dataB), .Out_Index(indexB), .Out_Last(lastB)
    );

    // Register file model with a synchronous read port per reader
    always @(posedge Clock) begin
        rdDataA <= regs[rdRegA];
        rdDataB <= regs[rdRegB];
    end

    assign selBusy  = dutSel ? busyB  : busyA;
    assign selDone  = dutSel ? doneB  : doneA;
    assign selValid = dutSel ? validB : validA;
    assign selLast  = dutSel ? lastB  : lastA;
    assign selRdReg = dutSel ? rdRegB : rdRegA;
    assign selIndex = dutSel ? indexB : indexA;
    assign selData  = dutSel ? dataB  : dataA;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveStart(input logic value);
        if (dutSel) startB = value;
        else        startA = value;
    endtask

    // Runs one dump on the selected reader and scores every handshaken word
    task automatic applyStimulus(input logic sel, input int first, input int last,
                                 input bit randomReady, input bit holdStart,
                                 input bit pulseMid, input bit checkLatency);
        int            nReg;
        int            nWords;
        int            k;
        int            c;
        int            lastHs;
        int            regHs;
        bit            doneSeen;
        bit            prevStall;
        bit            rdy;
        logic [31:0]   acc;
        logic [31:0]   expData;
        logic [AW-1:0] expIdx;
        logic          expLast;
        logic [DW-1:0] pd;
        logic [AW-1:0] pi;
        logic          pl;
        nReg      = last - first + 1;
        nWords    = nReg + (CSUM_EN ? 1 : 0);
        k         = 0;
        c         = 0;
        lastHs    = -1;
        regHs     = -1;
        doneSeen  = 1'b0;
        prevStall = 1'b0;
        acc       = '0;
        pd        = '0;
        pi        = '0;
        pl        = 1'b0;
        dutSel    = sel;
        @(negedge Clock);
        driveStart(1'b1);
        while (!doneSeen && c < 1000) begin
            @(negedge Clock);
            c++;
            if (!holdStart) begin
                if (pulseMid && (c == 20)) driveStart(1'b1);
                else                       driveStart(1'b0);
            end
            if (c == 1) begin
                checkOutput("busyAfterStart", 32'(selBusy), 32'd1);
                checkOutput("rdRegFirst", 32'(selRdReg), 32'(first));
            end
            rdy      = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            outReady = rdy;
            if (prevStall) begin
                checkOutput("stallValid", 32'(selValid), 32'd1);
                checkOutput("stallData", selData, pd);
                checkOutput("stallIndex", 32'(selIndex), 32'(pi));
                checkOutput("stallLast", 32'(selLast), 32'(pl));
            end
            if (selValid && rdy) begin
                if (k < nReg) begin
                    expIdx  = AW'(first + k);
                    expData = regs[expIdx];
                    expLast = (k == nReg - 1) && !CSUM_EN;
                    acc     = acc ^ expData;
                    if (k == nReg - 1) regHs = c;
                end else begin
                    expIdx  = AW'(last);
                    expData = acc;
                    expLast = 1'b1;
                end
                if (k < nWords) begin
                    checkOutput("wordIndex", 32'(selIndex), 32'(expIdx));
                    checkOutput("wordData", selData, expData);
                    checkOutput("wordLast", 32'(selLast), 32'(expLast));
                end else begin
                    checkOutput("extraWord", 32'(k), 32'(nWords - 1));
                end
                k++;
                lastHs = c;
            end
            prevStall = selValid && !rdy;
            pd = selData;
            pi = selIndex;
            pl = selLast;
            if (selDone) begin
                doneSeen = 1'b1;
                checkOutput("doneAfterLast", 32'(c), 32'(lastHs + 1));
                checkOutput("wordCount", 32'(k), 32'(nWords));
                checkOutput("busyInDone", 32'(selBusy), 32'd1);
                checkOutput("validInDone", 32'(selValid), 32'd0);
            end
        end
        if (!doneSeen) checkOutput("doneTimeout", 32'd0, 32'd1);
        if (checkLatency) checkOutput("latency", 32'(regHs), 32'(3 * nReg));
        if (CSUM_EN && sel == 1'b0 && first == 0 && last == 31)
            checkOutput("csumConst", acc, 32'h0000_1FFC);
        if (!holdStart) begin
            @(negedge Clock);
            checkOutput("donePulseOnce", 32'(selDone), 32'd0);
            checkOutput("busyCleared", 32'(selBusy), 32'd0);
            checkOutput("rdRegHolds", 32'(selRdReg), 32'(last));
        end
        outReady = 1'b1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        Reset    = 1'b1;
        startA   = 1'b0;
        startB   = 1'b0;
        outReady = 1'b0;
        dutSel   = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[17] = 32'h2;
        regs[18] = 32'h1;
        regs[29] = 32'h1FFF;
        repeat (3) @(negedge Clock);

        checkOutput("rstBusy", 32'(busyA), 32'd0);
        checkOutput("rstDone", 32'(doneA), 32'd0);
        checkOutput("rstValid", 32'(validA), 32'd0);
        checkOutput("rstLast", 32'(lastA), 32'd0);
        checkOutput("rstData", dataA, 32'd0);
        checkOutput("rstIndex", 32'(indexA), 32'd0);
        checkOutput("rstRdReg", 32'(rdRegA), 32'd0);
        checkOutput("rstRdRegB", 32'(rdRegB), 32'd0);
        Reset = 1'b0;

        $display("[TB] full dump, consumer always ready");
        applyStimulus(1'b0, 0, 31, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] full dump, random backpressure, stray Start mid-dump");
        applyStimulus(1'b0, 0, 31, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("[TB] sub-range dump 17..18");
        applyStimulus(1'b1, 17, 18, 1'b0, 1'b0, 1'b0, 1'b0);
        dutSel = 1'b0;

        $display("[TB] reset while word 5 waits in SEND");
        outReady = 1'b0;
        found    = 1'b0;
        @(negedge Clock);
        startA = 1'b1;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge Clock);
            startA = 1'b0;
            if (validA && indexA == 5'd5) begin
                found    = 1'b1;
                outReady = 1'b0;
                Reset    = 1'b1;
            end else begin
                outReady = validA;
            end
        end
        if (!found) checkOutput("reachIdx5", 32'd0, 32'd1);
        @(negedge Clock);
        checkOutput("abortValid", 32'(validA), 32'd0);
        checkOutput("abortBusy", 32'(busyA), 32'd0);
        checkOutput("abortDone", 32'(doneA), 32'd0);
        Reset    = 1'b0;
        outReady = 1'b1;
        repeat (2) @(negedge Clock);
        checkOutput("noWordAfterAbort", 32'(validA), 32'd0);
        applyStimulus(1'b0, 0, 31, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] Start held high: back-to-back dumps");
        applyStimulus(1'b0, 0, 31, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge Clock);
        checkOutput("idleGapBusy", 32'(busyA), 32'd0);
        @(negedge Clock);
        checkOutput("restartBusy", 32'(busyA), 32'd1);
        checkOutput("restartRdReg", 32'(rdRegA), 32'd0);
        startA = 1'b0;
        Reset  = 1'b1;
        repeat (2) @(negedge Clock);
        Reset  = 1'b0;
        checkOutput("finalIdle", 32'(busyA), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
